// File: rtl/constraint_scan_ctrl_if.sv
// rtl/constraint_scan_ctrl_if.sv - scan request / checker / result bundle for constraint_scan_ctrl
//
// Ports (all carried as interface members):
//   start      scan request from the solver front end
//   lo, hi     inclusive candidate range, sampled when a scan is accepted
//   abort      terminate the running scan without a completion pulse
//   chk_x      combinational checker verdict for the candidate on cand
//   cand       candidate value driven to the checker
//   busy       scan in progress (SCAN or DONE)
//   done       one-cycle completion pulse
//   found      at least one satisfying candidate this scan
//   first_sat  lowest satisfying candidate
//   sat_count  number of satisfying candidates, saturating
//   aborted    last scan was ended by abort
// Modports: master = front end plus checker side, slave = the controller.
interface constraint_scan_ctrl_if #(
  parameter int VAR_W = 39,
  parameter int CNT_W = 16
);
  logic             start;
  logic [VAR_W-1:0] lo;
  logic [VAR_W-1:0] hi;
  logic             abort;
  logic             chk_x;
  logic [VAR_W-1:0] cand;
  logic             busy;
  logic             done;
  logic             found;
  logic [VAR_W-1:0] first_sat;
  logic [CNT_W-1:0] sat_count;
  logic             aborted;

  modport master (
    output start, lo, hi, abort, chk_x,
    input  cand, busy, done, found, first_sat, sat_count, aborted
  );

  modport slave (
    input  start, lo, hi, abort, chk_x,
    output cand, busy, done, found, first_sat, sat_count, aborted
  );
endinterface

// File: rtl/constraint_scan_ctrl.sv
// rtl/constraint_scan_ctrl.sv - sweeps one solver variable over [lo, hi] through an external checker
//
// Issues one candidate per clock on cand, samples the checker verdict chk_x
// at the following edge, counts satisfying candidates (saturating) and
// captures the lowest one. All outputs are registered.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset, clears every output
//   bus    constraint_scan_ctrl_if.slave (start/lo/hi/abort/chk_x in,
//          cand/busy/done/found/first_sat/sat_count/aborted out)
//
// Build option CONSTRAINT_SCAN_EARLY_EXIT_EN: when defined the scan stops
// at the first satisfying candidate; otherwise the full range is scanned.
module constraint_scan_ctrl #(
  parameter int VAR_W = 39,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  constraint_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [VAR_W-1:0] VAR_ONE = {{(VAR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [VAR_W-1:0] cand_q;
  logic [VAR_W-1:0] hi_q;
  logic [VAR_W-1:0] first_sat_q;
  logic [CNT_W-1:0] sat_count_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic             aborted_q;

  logic [CNT_W-1:0] sat_count_d;
  logic [VAR_W-1:0] cand_d;
  logic             last_d;
  logic             stop_d;

  // Counter sticks at all-ones instead of wrapping.
  assign sat_count_d = (&sat_count_q) ? sat_count_q : sat_count_q + CNT_ONE;
  assign cand_d      = cand_q + VAR_ONE;

  // End of range is an equality test against the latched bound, so a range
  // ending at all-ones terminates without cand ever wrapping to zero.
  assign last_d = (cand_q == hi_q);

`ifdef CONSTRAINT_SCAN_EARLY_EXIT_EN
  assign stop_d = last_d | bus.chk_x;
`else
  assign stop_d = last_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      hi_q        <= '0;
      first_sat_q <= '0;
      sat_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            hi_q        <= bus.hi;
            cand_q      <= bus.lo;
            found_q     <= 1'b0;
            first_sat_q <= '0;
            sat_count_q <= '0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b1;
            // An empty range completes straight away with zero results.
            if (bus.lo > bus.hi) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
          if (bus.abort) begin
            // The verdict for the candidate on the bus this cycle is dropped.
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
            if (bus.chk_x) begin
              sat_count_q <= sat_count_d;
              if (!found_q) begin
                found_q     <= 1'b1;
                first_sat_q <= cand_q;
              end
            end
            if (stop_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              cand_q <= cand_d;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cand      = cand_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.first_sat = first_sat_q;
  assign bus.sat_count = sat_count_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_constraint_scan_ctrl.sv
// tb/tb_constraint_scan_ctrl.sv - self-checking bench for constraint_scan_ctrl
module tb_constraint_scan_ctrl;
  localparam int VW = 39;
  localparam logic [VW-1:0] ALL1 = {VW{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_r;
  logic          abort_r;
  logic [VW-1:0] lo_r;
  logic [VW-1:0] hi_r;
  int            chk_mode;
  logic [VW-1:0] chk_mask;
  logic          chk_inv;

  int cmps = 0;
  int errs = 0;

  constraint_scan_ctrl_if #(.VAR_W(VW), .CNT_W(16)) bus_a ();
  constraint_scan_ctrl_if #(.VAR_W(VW), .CNT_W(4))  bus_b ();

  // Checker model: 0 = x is (v != key), 1 = always true, 2 = masked parity, 3 = never.
  function automatic logic chk_f(input logic [VW-1:0] v, input int mode,
                                 input logic [VW-1:0] m, input logic inv);
    case (mode)
      0:       return (v != 39'h276a2911cf);
      1:       return 1'b1;
      2:       return (^(v & m)) ^ inv;
      default: return 1'b0;
    endcase
  endfunction

  assign bus_a.start = start_r;
  assign bus_a.lo    = lo_r;
  assign bus_a.hi    = hi_r;
  assign bus_a.abort = abort_r;
  assign bus_a.chk_x = chk_f(bus_a.cand, chk_mode, chk_mask, chk_inv);
  assign bus_b.start = start_r;
  assign bus_b.lo    = lo_r;
  assign bus_b.hi    = hi_r;
  assign bus_b.abort = abort_r;
  assign bus_b.chk_x = chk_f(bus_b.cand, chk_mode, chk_mask, chk_inv);

  constraint_scan_ctrl #(.VAR_W(VW), .CNT_W(16)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  constraint_scan_ctrl #(.VAR_W(VW), .CNT_W(4))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  // Reference: walks the range value by value. edges = edges after the start
  // edge until done is visible, -1 when the scan is aborted.
  task automatic model(input logic [VW-1:0] lo, input logic [VW-1:0] hi, input int abort_at,
                       output int edges, output logic found, output logic [VW-1:0] first,
                       output int cnt, output logic ab, output logic [VW-1:0] last_cand);
    longint n;
    logic [VW-1:0] v;
    edges = 0; found = 1'b0; first = '0; cnt = 0; ab = 1'b0; last_cand = lo;
    if (lo > hi) return;
    n = longint'({1'b0, hi}) - longint'({1'b0, lo}) + 1;
    edges = int'(n);
    for (longint i = 0; i < n; i++) begin
      v = lo + i[VW-1:0];
      last_cand = v;
      if (longint'(abort_at) == i + 1) begin
        ab = 1'b1;
        edges = -1;
        break;
      end
      if (chk_f(v, chk_mode, chk_mask, chk_inv)) begin
        cnt++;
        if (!found) begin
          found = 1'b1;
          first = v;
        end
`ifdef CONSTRAINT_SCAN_EARLY_EXIT_EN
        edges = int'(i) + 1;
        break;
`endif
      end
    end
  endtask

  task automatic run_scan(input logic [VW-1:0] lo, input logic [VW-1:0] hi, input int abort_at);
    int e_edges, e_cnt, k;
    logic e_found, e_ab, range_ok;
    logic [VW-1:0] e_first, e_last;
    logic [15:0] e_sat_a;
    logic [3:0] e_sat_b;
    model(lo, hi, abort_at, e_edges, e_found, e_first, e_cnt, e_ab, e_last);
    e_sat_a = (e_cnt > 65535) ? 16'hffff : e_cnt[15:0];
    e_sat_b = (e_cnt > 15) ? 4'hf : e_cnt[3:0];

    for (int w = 0; w < 100 && bus_a.busy === 1'b1; w++) begin
      @(posedge clk); #1;
    end
    start_r = 1'b1; lo_r = lo; hi_r = hi;
    @(posedge clk); #1;
    start_r = 1'b0;
    lo_r = VW'({$urandom(), $urandom()});
    hi_r = VW'({$urandom(), $urandom()});
    cmps++;
    if (bus_a.busy !== 1'b1 || bus_a.cand !== lo) begin
      errs++;
      $display("FAIL start_accept: busy=%b cand=%h expected busy=1 cand=%h", bus_a.busy, bus_a.cand, lo);
    end

    k = 0;
    range_ok = 1'b1;
    while (k < 200) begin
      if (bus_a.done === 1'b1) break;
      if (k > 0 && bus_a.busy !== 1'b1) break;
      abort_r = (abort_at == k + 1);
      @(posedge clk); #1;
      abort_r = 1'b0;
      k++;
      if (lo <= hi && bus_a.busy === 1'b1 && (bus_a.cand < lo || bus_a.cand > hi)) range_ok = 1'b0;
    end

    if (e_edges >= 0) begin
      cmps++;
      if (bus_a.done !== 1'b1 || bus_b.done !== 1'b1 || k != e_edges) begin
        errs++;
        $display("FAIL done_latency: done_a=%b done_b=%b edges=%0d expected done=1 edges=%0d",
                 bus_a.done, bus_b.done, k, e_edges);
      end
    end else begin
      cmps++;
      if (bus_a.done === 1'b1 || bus_a.busy !== 1'b0 || k != abort_at) begin
        errs++;
        $display("FAIL abort_exit: done=%b busy=%b edges=%0d expected done=0 busy=0 edges=%0d",
                 bus_a.done, bus_a.busy, k, abort_at);
      end
    end
    cmps++;
    if (bus_a.cand !== e_last || range_ok !== 1'b1) begin
      errs++;
      $display("FAIL cand_final: cand=%h in_range=%b expected cand=%h in_range=1", bus_a.cand, range_ok, e_last);
    end
    cmps++;
    if (bus_a.found !== e_found || bus_a.first_sat !== e_first) begin
      errs++;
      $display("FAIL first_sat: found=%b first=%h expected found=%b first=%h",
               bus_a.found, bus_a.first_sat, e_found, e_first);
    end
    cmps++;
    if (bus_a.sat_count !== e_sat_a) begin
      errs++;
      $display("FAIL sat_count16: got %0d expected %0d", bus_a.sat_count, e_sat_a);
    end
    cmps++;
    if (bus_b.sat_count !== e_sat_b || bus_b.found !== e_found) begin
      errs++;
      $display("FAIL sat_count4: got %0d found=%b expected %0d found=%b",
               bus_b.sat_count, bus_b.found, e_sat_b, e_found);
    end
    cmps++;
    if (bus_a.aborted !== e_ab || bus_b.aborted !== e_ab) begin
      errs++;
      $display("FAIL aborted_flag: a=%b b=%b expected %b", bus_a.aborted, bus_b.aborted, e_ab);
    end

    if (e_edges >= 0) begin
      // start while DONE must be ignored and results must hold.
      start_r = 1'b1; lo_r = '0; hi_r = VW'(5);
      @(posedge clk); #1;
      start_r = 1'b0;
      cmps++;
      if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 || bus_a.sat_count !== e_sat_a ||
          bus_a.found !== e_found || bus_a.first_sat !== e_first) begin
        errs++;
        $display("FAIL start_in_done: busy=%b done=%b cnt=%0d found=%b expected busy=0 done=0 cnt=%0d found=%b",
                 bus_a.busy, bus_a.done, bus_a.sat_count, bus_a.found, e_sat_a, e_found);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_r = 1'b0; abort_r = 1'b0; lo_r = '0; hi_r = '0;
    chk_mode = 1; chk_mask = '0; chk_inv = 1'b0;
    #1;
    cmps++;
    if ({bus_a.busy, bus_a.done, bus_a.found, bus_a.aborted} !== 4'b0 || bus_a.cand !== '0 ||
        bus_a.first_sat !== '0 || bus_a.sat_count !== '0 || bus_b.sat_count !== '0) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b cand=%h cnt=%0d expected all zero",
               bus_a.busy, bus_a.done, bus_a.cand, bus_a.sat_count);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    chk_mode = 0;
    run_scan(39'h276a2911ce, 39'h276a2911d0, 0);
    run_scan(39'h276a2911cf, 39'h276a2911cf, 0);
    run_scan(39'h10, 39'h0f, 0);
    chk_mode = 1;
    run_scan(ALL1 - VW'(2), ALL1, 0);
  endtask

  task automatic test_saturation_abort();
    chk_mode = 1;
    run_scan(VW'(1000), VW'(1019), 0);
    run_scan(VW'(1000), VW'(1019), 6);
    chk_mode = 2; chk_mask = VW'(39'h55); chk_inv = 1'b0;
    run_scan(VW'(7), VW'(30), 1);
  endtask

  task automatic test_abort_idle();
    int e_edges, e_cnt;
    logic e_found, e_ab;
    logic [VW-1:0] e_first, e_last;
    chk_mode = 1;
    run_scan(VW'(0), VW'(3), 0);
    model(VW'(0), VW'(3), 0, e_edges, e_found, e_first, e_cnt, e_ab, e_last);
    abort_r = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    abort_r = 1'b0;
    cmps++;
    if (bus_a.aborted !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.sat_count !== e_cnt[15:0]) begin
      errs++;
      $display("FAIL abort_in_idle: aborted=%b busy=%b cnt=%0d expected aborted=0 busy=0 cnt=%0d",
               bus_a.aborted, bus_a.busy, bus_a.sat_count, e_cnt);
    end
  endtask

  task automatic test_midscan_reset();
    chk_mode = 1;
    start_r = 1'b1; lo_r = VW'(100); hi_r = VW'(200);
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmps++;
    if ({bus_a.busy, bus_a.done, bus_a.found, bus_a.aborted} !== 4'b0 || bus_a.cand !== '0 ||
        bus_a.first_sat !== '0 || bus_a.sat_count !== '0 || bus_b.sat_count !== '0 || bus_b.busy !== 1'b0) begin
      errs++;
      $display("FAIL midscan_reset: busy=%b cand=%h cnt=%0d found=%b expected all zero",
               bus_a.busy, bus_a.cand, bus_a.sat_count, bus_a.found);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_mode = 0;
    run_scan(39'h276a2911cd, 39'h276a2911d1, 0);
  endtask

  task automatic test_random();
    logic [VW-1:0] lo, hi;
    int size, ab;
    for (int it = 0; it < 24; it++) begin
      chk_mode = $urandom_range(0, 3);
      chk_mask = VW'({$urandom(), $urandom()});
      chk_inv  = 1'($urandom_range(0, 1));
      lo = VW'({$urandom(), $urandom()});
      size = $urandom_range(0, 40);
      if (it % 5 == 1) lo = ALL1 - VW'($urandom_range(0, 45));
      if (size == 0) begin
        if (lo < VW'(64)) lo = lo + VW'(64);
        hi = lo - VW'($urandom_range(1, 50));
      end else begin
        if (lo > ALL1 - VW'(size - 1)) lo = ALL1 - VW'(size - 1);
        hi = lo + VW'(size - 1);
      end
      ab = ($urandom_range(0, 3) == 0 && size > 0) ? $urandom_range(1, size) : 0;
      run_scan(lo, hi, ab);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_saturation_abort();
    test_abort_idle();
    test_midscan_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
